// File: rtl/button_event_decoder_pkg.sv
// Shared types and helpers for the button event decoder.
package btn_evt_pkg;

  // FSM states of the decoder.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG,
    ST_GAP,
    ST_HELD2
  } btn_state_t;

  // Counter width large enough to reach the largest terminal count.
  function automatic int cnt_width(input int long_c, input int rep_c, input int gap_c);
    int m;
    m = long_c;
    if (rep_c > m) m = rep_c;
    if (gap_c > m) m = gap_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, event pulses out.
interface button_event_decoder_if;
  logic level;
  logic press_p;
  logic release_p;
  logic short_p;
  logic long_p;
  logic repeat_p;
  logic double_p;
  logic busy;

  modport master (
    output level,
    input  press_p, release_p, short_p, long_p, repeat_p, double_p, busy
  );

  modport slave (
    input  level,
    output press_p, release_p, short_p, long_p, repeat_p, double_p, busy
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/repeat/double pulses.
//
// state | meaning
// IDLE  | button up, nothing pending
// HELD  | first press held, timing towards long
// LONG  | held past long, emitting repeats
// GAP   | released, waiting for a possible second press
// HELD2 | second press of a double click held
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int DBL_GAP       = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_event_decoder_if.slave  bus
);

  localparam int CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES, DBL_GAP);
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'((DBL_GAP > 0) ? DBL_GAP - 1 : 0);

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic press_q, press_d;
  logic rel_q, rel_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic dbl_q, dbl_d;
  logic busy_q, busy_d;

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    press_d = 1'b0;
    rel_d   = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    dbl_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // no timing here; hold the counter parked
        cnt_d = '0;
        if (bus.level) begin
          press_d = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        // release is checked first so it beats a coincident long terminal count
        if (!bus.level) begin
          rel_d = 1'b1;
          if (DBL_GAP > 0) begin
            state_d = ST_GAP;
          end else begin
            short_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == LONG_TC) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_LONG: begin
        if (!bus.level) begin
          rel_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == REP_TC) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end
      end
      ST_GAP: begin
        // a re-press beats a coincident gap terminal count
        if (bus.level) begin
          press_d = 1'b1;
          dbl_d   = 1'b1;
          state_d = ST_HELD2;
        end else if (cnt_q == GAP_TC) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HELD2: begin
        cnt_d = '0;
        if (!bus.level) begin
          rel_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      dbl_q   <= dbl_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.press_p   = press_q;
  assign bus.release_p = rel_q;
  assign bus.short_p   = short_q;
  assign bus.long_p    = long_q;
  assign bus.repeat_p  = rep_q;
  assign bus.double_p  = dbl_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench: default-gap decoder plus a no-double-click variant on the same stimulus.
module tb_button_event_decoder;
  import btn_evt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // bit map: 0 press, 1 release, 2 short, 3 long, 4 repeat, 5 double, 6 busy
  logic [6:0] log1 [64];
  logic [6:0] log0 [64];

  button_event_decoder_if bus1 ();
  button_event_decoder_if bus0 ();

  button_event_decoder #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .DBL_GAP(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );
  button_event_decoder #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .DBL_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs1();
    return {bus1.busy, bus1.double_p, bus1.repeat_p, bus1.long_p,
            bus1.short_p, bus1.release_p, bus1.press_p};
  endfunction

  function automatic logic [6:0] outs0();
    return {bus0.busy, bus0.double_p, bus0.repeat_p, bus0.long_p,
            bus0.short_p, bus0.release_p, bus0.press_p};
  endfunction

  function automatic int first_of(input bit sel0, input int b);
    for (int i = 0; i < 64; i++) begin
      if (sel0 ? log0[i][b] : log1[i][b]) return i;
    end
    return -1;
  endfunction

  function automatic int count_of(input bit sel0, input int b);
    int n = 0;
    for (int i = 0; i < 64; i++) begin
      if (sel0 ? log0[i][b] : log1[i][b]) n++;
    end
    return n;
  endfunction

  // cycles where more than one of short/long/double is high
  function automatic int multi_evt(input bit sel0);
    int n = 0;
    logic [6:0] v;
    for (int i = 0; i < 64; i++) begin
      v = sel0 ? log0[i] : log1[i];
      if ((int'(v[2]) + int'(v[3]) + int'(v[5])) > 1) n++;
    end
    return n;
  endfunction

  // Level is 1 for h1 samples, 0 for g, 1 for h2, then 0; cycle 0 is the first press.
  task automatic run_seq(input int h1, input int g, input int h2, input int total);
    logic lv;
    for (int i = 0; i < 64; i++) begin
      log1[i] = '0;
      log0[i] = '0;
    end
    for (int c = 0; c < total; c++) begin
      if (c < h1) lv = 1'b1;
      else if (c < h1 + g) lv = 1'b0;
      else if (c < h1 + g + h2) lv = 1'b1;
      else lv = 1'b0;
      bus1.level = lv;
      bus0.level = lv;
      @(posedge clk);
      #1;
      log1[c] = outs1();
      log0[c] = outs0();
    end
  endtask

  initial begin
    bus1.level = 1'b0;
    bus0.level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs1", int'(outs1()), 0);
    chk("reset_outs0", int'(outs0()), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // short press: 3 samples held
    run_seq(3, 0, 0, 14);
    chk("s1_press_idx", first_of(0, 0), 0);
    chk("s1_busy_at_press", int'(log1[0][6]), 1);
    chk("s1_release_idx", first_of(0, 1), 3);
    chk("s1_short_idx", first_of(0, 2), 8);
    chk("s1_long_cnt", count_of(0, 3), 0);
    chk("s1_busy_end", int'(log1[13][6]), 0);
    chk("s1g0_release_idx", first_of(1, 1), 3);
    chk("s1g0_short_idx", first_of(1, 2), 3);
    chk("s1g0_short_cnt", count_of(1, 2), 1);
    chk("s1g0_busy_end", int'(log0[5][6]), 0);

    // long hold with repeats: 20 samples held
    run_seq(20, 0, 0, 30);
    chk("s2_long_idx", first_of(0, 3), 8);
    chk("s2_long_cnt", count_of(0, 3), 1);
    chk("s2_rep_cnt", count_of(0, 4), 2);
    chk("s2_rep_first", first_of(0, 4), 12);
    chk("s2_rep_16", int'(log1[16][4]), 1);
    chk("s2_release_idx", first_of(0, 1), 20);
    chk("s2_short_cnt", count_of(0, 2), 0);
    chk("s2_busy_held", int'(log1[19][6]), 1);
    chk("s2_busy_end", int'(log1[25][6]), 0);

    // double click: 2 high, 2 low, 2 high
    run_seq(2, 2, 2, 16);
    chk("s3_press_cnt", count_of(0, 0), 2);
    chk("s3_double_idx", first_of(0, 5), 4);
    chk("s3_press_at_dbl", int'(log1[4][0]), 1);
    chk("s3_release_cnt", count_of(0, 1), 2);
    chk("s3_short_cnt", count_of(0, 2), 0);
    chk("s3_multi", multi_evt(0), 0);
    chk("s3g0_double_cnt", count_of(1, 5), 0);
    chk("s3g0_short_cnt", count_of(1, 2), 2);

    // release on the long terminal edge: 8 samples held
    run_seq(8, 0, 0, 20);
    chk("s4_release_idx", first_of(0, 1), 8);
    chk("s4_long_cnt", count_of(0, 3), 0);
    chk("s4_short_idx", first_of(0, 2), 13);

    // re-press on the gap terminal edge
    run_seq(3, 5, 2, 16);
    chk("s5_double_idx", first_of(0, 5), 8);
    chk("s5_short_cnt", count_of(0, 2), 0);
    chk("s5_press_cnt", count_of(0, 0), 2);
    chk("s5_multi", multi_evt(0), 0);

    // one gap cycle too long: short fires, then a fresh single press
    run_seq(3, 6, 2, 20);
    chk("s6_short_idx", first_of(0, 2), 8);
    chk("s6_double_cnt", count_of(0, 5), 0);
    chk("s6_press2_at9", int'(log1[9][0]), 1);

    // async reset while in LONG, landing on a repeat cycle
    bus1.level = 1'b1;
    bus0.level = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_pre_repeat", int'(bus1.repeat_p), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", int'(outs1()), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_outs", int'(outs1()), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_press_after", int'(bus1.press_p), 1);
    chk("rst_busy_after", int'(bus1.busy), 1);
    bus1.level = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("final_idle", int'(bus1.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
